// File: rtl/led_stream_fader_pkg.sv
// Shared definitions for the LED stream fader: stream/brightness widths,
// the stb/ack handshake states and the saturating brightness decrement.
package led_stream_fader_pkg;

    localparam int STREAM_W = 32;
    localparam int BRIGHT_W = 8;
    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 8'hFF;

    // Handshake state doubles as the registered ack output.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    // Brightness decrement that stops at zero instead of wrapping.
    function automatic logic [BRIGHT_W-1:0] sat_sub(
        input logic [BRIGHT_W-1:0] val,
        input logic [BRIGHT_W-1:0] step
    );
        logic [BRIGHT_W-1:0] res;
        if (val > step) begin
            res = val - step;
        end else begin
            res = 8'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/led_stream_fader_channel.sv
// One LED's afterglow channel: 8-bit brightness register, saturating decay
// on each decay tick and a registered PWM compare against the shared counter.
module led_fade_channel
    import led_stream_fader_pkg::*;
#(
    parameter int DECAY_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_i,
    input  logic                decay_tick_i,
    input  logic [BRIGHT_W-1:0] pwm_cnt_i,
    output logic                led_o
);

    localparam logic [BRIGHT_W-1:0] STEP = BRIGHT_W'(DECAY_STEP);

    logic [BRIGHT_W-1:0] bright_q;
    logic [BRIGHT_W-1:0] bright_d;
    logic                led_q;
    logic                led_d;

    // Next brightness: a lit bit pins full scale, otherwise decay on tick or hold.
    always_comb begin
        bright_d = bright_q;
        if (set_i) begin
            bright_d = BRIGHT_MAX;
        end else if (decay_tick_i) begin
            bright_d = sat_sub(bright_q, STEP);
        end else begin
            bright_d = bright_q;
        end
    end

    // PWM compare; full scale is forced on so 255 is a solid 100% duty.
    always_comb begin
        led_d = (bright_q == BRIGHT_MAX) || (bright_q > pwm_cnt_i);
    end

    // Brightness and LED output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= 8'd0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_stream_fader.sv
// Stream sink for the 32-bit LED pattern stream; drives the board LEDs.
// Optional feature macro: LED_FADE_EN -- when defined each LED gets a
// decaying PWM afterglow; when undefined the pattern is driven straight out.
module led_stream_fader
    import led_stream_fader_pkg::*;
#(
    parameter int NUM_LEDS   = 16,
    parameter int DECAY_DIV  = 100000,
    parameter int DECAY_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STREAM_W-1:0] input_leds,
    input  logic                input_leds_stb,
    output logic                input_leds_ack,
    output logic [NUM_LEDS-1:0] leds
);

    if (DECAY_DIV < 2 || DECAY_STEP < 1 || DECAY_STEP > 255 ||
        NUM_LEDS < 1 || NUM_LEDS > STREAM_W) begin : g_bad_params
        $error("led_stream_fader: illegal parameter combination");
    end

    // Stream bits above NUM_LEDS carry no LEDs and are dropped.
    if (NUM_LEDS < STREAM_W) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = ^input_leds[STREAM_W-1:NUM_LEDS];
    end

    hs_state_e           hs_q;
    logic [NUM_LEDS-1:0] pattern_q;

    // Handshake: accept on stb while idle, ack for exactly one cycle, then idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= HS_IDLE;
            pattern_q <= '0;
        end else begin
            case (hs_q)
                HS_IDLE: begin
                    if (input_leds_stb) begin
                        hs_q      <= HS_ACK;
                        pattern_q <= input_leds[NUM_LEDS-1:0];
                    end else begin
                        hs_q <= HS_IDLE;
                    end
                end
                HS_ACK: begin
                    hs_q <= HS_IDLE;
                end
                default: begin
                    hs_q <= HS_IDLE;
                end
            endcase
        end
    end

    assign input_leds_ack = (hs_q == HS_ACK);

`ifdef LED_FADE_EN
    localparam int PRE_W = $clog2(DECAY_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [PRE_W-1:0]    pre_q;
    logic [PRE_W-1:0]    pre_d;
    logic [BRIGHT_W-1:0] pwm_q;
    logic [BRIGHT_W-1:0] pwm_d;
    logic                decay_tick_s;
    logic [NUM_LEDS-1:0] led_s;

    // Decay prescaler wraps at DECAY_DIV-1; the PWM counter free-runs.
    always_comb begin
        decay_tick_s = (pre_q == PRE_LAST);
        if (decay_tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
        pwm_d = pwm_q + 8'd1;
    end

    // Prescaler and PWM counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            pwm_q <= 8'd0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
        end
    end

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
        led_fade_channel #(
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .set_i        (pattern_q[n]),
            .decay_tick_i (decay_tick_s),
            .pwm_cnt_i    (pwm_q),
            .led_o        (led_s[n])
        );
    end

    assign leds = led_s;
`else
    logic [NUM_LEDS-1:0] leds_q;

    // Without fading the latched pattern is registered straight to the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= pattern_q;
        end
    end

    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_led_stream_fader.sv
// Directed self-checking bench for led_stream_fader (NUM_LEDS=16,
// DECAY_DIV=4, DECAY_STEP=64). Covers both LED_FADE_EN builds.
module tb_led_stream_fader;

    localparam int NL   = 16;
    localparam int DIV  = 4;
    localparam int STEP = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   data;
    logic          stb;
    logic          ack;
    logic [NL-1:0] leds;

    int n_err    = 0;
    int n_checks = 0;

    led_stream_fader #(
        .NUM_LEDS   (NL),
        .DECAY_DIV  (DIV),
        .DECAY_STEP (STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .input_leds     (data),
        .input_leds_stb (stb),
        .input_leds_ack (ack),
        .leds           (leds)
    );

    always #5 clk = ~clk;

`ifdef LED_FADE_EN
    // Cycle model of the fade path, stepped once per clock from the inputs.
    logic [NL-1:0] m_pat;
    logic [NL-1:0] m_led;
    logic          m_ack;
    int            m_pre;
    int            m_pwm;
    int            m_b[NL];

    task automatic model_step();
        logic [NL-1:0] n_led;
        logic          n_ack;
        logic          dt;
        if (rst) begin
            m_pat = '0;
            m_led = '0;
            m_ack = 1'b0;
            m_pre = 0;
            m_pwm = 0;
            for (int n = 0; n < NL; n++) m_b[n] = 0;
        end else begin
            dt = (m_pre == DIV - 1);
            for (int n = 0; n < NL; n++)
                n_led[n] = (m_b[n] == 255) || (m_b[n] > m_pwm);
            for (int n = 0; n < NL; n++) begin
                if (m_pat[n]) m_b[n] = 255;
                else if (dt) m_b[n] = (m_b[n] > STEP) ? m_b[n] - STEP : 0;
            end
            m_pre = dt ? 0 : m_pre + 1;
            m_pwm = (m_pwm + 1) % 256;
            n_ack = stb && !m_ack;
            if (n_ack) m_pat = data[NL-1:0];
            m_ack = n_ack;
            m_led = n_led;
        end
    endtask
`endif

    task automatic tick();
`ifdef LED_FADE_EN
        model_step();
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int acks;
        logic [31:0] words [3];
        words[0] = 32'hAAAA_8001;
        words[1] = 32'h5555_8003;
        words[2] = 32'h1234_8007;

        // Reset held three cycles with stb asserted.
        rst  = 1'b1;
        stb  = 1'b1;
`ifdef LED_FADE_EN
        data = 32'h0000_0001;
`else
        data = 32'h0000_00A5;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_ack", {31'd0, ack}, 32'd0);
            chk("reset_leds", {16'd0, leds}, 32'd0);
        end

        // First accept right after release.
        rst = 1'b0;
        tick();
        chk("first_ack", {31'd0, ack}, 32'd1);
        chk("first_leds_t0", {16'd0, leds}, 32'd0);
        stb = 1'b0;
`ifdef LED_FADE_EN
        tick();
        chk("ack_one_cycle", {31'd0, ack}, 32'd0);
        chk("led0_t1", {16'd0, leds}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("led0_on", {16'd0, leds}, 32'h0000_0001);
        end

        // Clear the pattern and watch the afterglow decay to dark.
        data = 32'h0;
        stb  = 1'b1;
        tick();
        chk("clr_ack", {31'd0, ack}, 32'd1);
        chk("clr_led_t0", {16'd0, leds}, 32'h0000_0001);
        stb = 1'b0;
        tick();
        chk("clr_led_t1", {16'd0, leds}, 32'h0000_0001);
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("decay_model", {16'd0, leds}, {16'd0, m_led});
        end
        for (int i = 0; i < 280; i++) begin
            tick();
            chk("no_wrap", {16'd0, leds}, 32'd0);
        end

        // Upper stream bits ignored.
        data = 32'hFFFF_8001;
        stb  = 1'b1;
        tick();
        chk("hi_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hi_ignored", {16'd0, leds}, 32'h0000_8001);
        end
`else
        tick();
        chk("ack_one_cycle", {31'd0, ack}, 32'd0);
        chk("a5_leds", {16'd0, leds}, 32'h0000_00A5);
        tick();
        chk("a5_hold", {16'd0, leds}, 32'h0000_00A5);

        // Clearing has no afterglow.
        data = 32'h0;
        stb  = 1'b1;
        tick();
        chk("clr_ack", {31'd0, ack}, 32'd1);
        chk("clr_led_t0", {16'd0, leds}, 32'h0000_00A5);
        stb = 1'b0;
        tick();
        chk("clr_leds", {16'd0, leds}, 32'd0);
        tick();
        chk("clr_hold", {16'd0, leds}, 32'd0);

        // Upper stream bits ignored.
        data = 32'hFFFF_8001;
        stb  = 1'b1;
        tick();
        chk("hi_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0;
        tick();
        chk("hi_ignored", {16'd0, leds}, 32'h0000_8001);
`endif

        // Back-to-back: stb held six cycles, data advanced after each ack.
        acks = 0;
        data = words[0];
        stb  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_ack", {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ack) begin
                acks++;
                if (i / 2 < 2) data = words[i / 2 + 1];
            end
`ifndef LED_FADE_EN
            if (i % 2 == 1)
                chk("b2b_leds", {16'd0, leds}, {16'd0, words[i / 2][15:0]});
`endif
        end
        stb = 1'b0;
        chk("b2b_count", acks, 32'd3);
        tick();
        tick();
        chk("b2b_final", {16'd0, leds}, 32'h0000_8007);

        // Reset during a handshake drops ack and discards the word.
        data = 32'h0000_00F0;
        stb  = 1'b1;
        rst  = 1'b1;
        tick();
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_leds", {16'd0, leds}, 32'd0);
        rst = 1'b0;
        stb = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_discard", {16'd0, leds}, 32'd0);
        chk("midrst_noack", {31'd0, ack}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
